// File: rtl/pkt_send_gen_if.sv
// ---------------------------------------------------------------------------
// pkt_send_gen_if
//   Command / packet-output bundle for pkt_send_gen.
//   slave  : the generator (consumes commands and hold, drives packet words)
//   master : the user side (issues commands, applies backpressure)
//
//   start_i      command valid
//   dest_i       destination port            [WS-1:0]
//   priority_i   packet priority             [WP-1:0]
//   length_i     payload words               [WL-1:0]
//   start_rdy_o  command queue can take a command
//   hold_i       downstream backpressure
//   wr_sop_o     first word of packet
//   wr_eop_o     last word of packet
//   wr_vld_o     word valid
//   wr_data_o    packet word                 [DATA_WIDTH-1:0]
//   done_o       one-cycle pulse with the final word
//   busy_o       queue non-empty or packet in flight
// ---------------------------------------------------------------------------
interface pkt_send_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PORT_NUB   = 16,
    parameter int PRIORITY   = 8,
    parameter int LENGTH_MAX = 64
);
    localparam int WS = $clog2(PORT_NUB);
    localparam int WP = $clog2(PRIORITY);
    localparam int WL = $clog2(LENGTH_MAX);

    logic                  start_i;
    logic [WS-1:0]         dest_i;
    logic [WP-1:0]         priority_i;
    logic [WL-1:0]         length_i;
    logic                  start_rdy_o;
    logic                  hold_i;
    logic                  wr_sop_o;
    logic                  wr_eop_o;
    logic                  wr_vld_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  done_o;
    logic                  busy_o;

    modport slave (
        input  start_i, dest_i, priority_i, length_i, hold_i,
        output start_rdy_o, wr_sop_o, wr_eop_o, wr_vld_o, wr_data_o, done_o, busy_o
    );

    modport master (
        output start_i, dest_i, priority_i, length_i, hold_i,
        input  start_rdy_o, wr_sop_o, wr_eop_o, wr_vld_o, wr_data_o, done_o, busy_o
    );
endinterface

// File: rtl/pkt_send_gen.sv
// ---------------------------------------------------------------------------
// pkt_send_gen
//   Queues send commands (dest, priority, length) in a small FIFO and turns
//   each one into a packet: a header word {seq, length, priority, dest},
//   `length` payload words (seq*256 + k + 1), then IPG idle cycles before the
//   next packet. seq counts completed packets.
//
//   Optional macro SEND_CHECKSUM_EN: append an XOR checksum word of all
//   preceding words of the packet; that word carries eop.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      pkt_send_gen_if.slave (command inputs, hold, wr_* outputs,
//            start_rdy, done, busy)
// ---------------------------------------------------------------------------
module pkt_send_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int PORT_NUB   = 16,
    parameter int PRIORITY   = 8,
    parameter int LENGTH_MAX = 64,
    parameter int CMD_DEPTH  = 4,
    parameter int IPG        = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pkt_send_gen_if.slave bus
);
    localparam int WS       = $clog2(PORT_NUB);
    localparam int WP       = $clog2(PRIORITY);
    localparam int WL       = $clog2(LENGTH_MAX);
    localparam int WQ       = $clog2(CMD_DEPTH);
    localparam int HW       = 16 + WL + WP + WS;
    localparam int WG       = (IPG > 1) ? $clog2(IPG) : 1;
    localparam int GAP_LAST = (IPG > 0) ? IPG - 1 : 0;

    typedef struct packed {
        logic [WL-1:0] len;
        logic [WP-1:0] prio;
        logic [WS-1:0] dest;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_BODY = 3'd2,
`ifdef SEND_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_GAP  = 3'd4
    } state_t;

    // ---------------- command FIFO ----------------
    cmd_t          q_mem [CMD_DEPTH];
    logic [WQ-1:0] wp_q, rp_q;
    logic [WQ:0]   cnt_q, cnt_d;
    logic          rdy_q;
    logic          push, pop;
    cmd_t          cmd_in, q_head;

    assign cmd_in = {bus.length_i, bus.priority_i, bus.dest_i};
    assign push   = bus.start_i & rdy_q;
    assign q_head = q_mem[rp_q];
    assign cnt_d  = cnt_q + (WQ+1)'(push) - (WQ+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) q_mem[wp_q] <= cmd_in;
    end

    // rdy is a register so it reads 0 during reset and rises on the first
    // edge after release; it tracks "not full" of the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            if (push) wp_q <= wp_q + WQ'(1);
            if (pop)  rp_q <= rp_q + WQ'(1);
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != (WQ+1)'(CMD_DEPTH));
        end
    end

    // ---------------- packet FSM ----------------
    state_t                state_q, state_d;
    logic [WL-1:0]         ptr_q, ptr_d;
    logic [WG-1:0]         gap_q, gap_d;
    cmd_t                  cmd_q, cmd_d;
    logic [15:0]           seq_q, seq_d;
    logic                  vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, done_q, done_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] hdr, pay;
    logic                  launch, last_word, pkt_end, can_launch;
`ifdef SEND_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

    // A new packet only starts when its header can go out immediately, so a
    // held output never pops the queue and HEAD is never a pending state.
    assign can_launch = (cnt_q != '0) && !bus.hold_i;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        cmd_d     = cmd_q;
        pop       = 1'b0;
        launch    = 1'b0;
        last_word = 1'b0;
        pkt_end   = 1'b0;

        // In a sending state, vld_q says the current word went out last
        // cycle; if it did not (hold), the same word stays pending.
        case (state_q)
            S_IDLE: launch = can_launch;
            S_GAP: begin
                gap_d = gap_q + WG'(1);
                if (gap_q == WG'(GAP_LAST)) begin
                    state_d = S_IDLE;
                    launch  = can_launch;
                end
            end
            S_HEAD: if (vld_q) begin
                if (cmd_q.len != '0) begin
                    state_d = S_BODY;
                    ptr_d   = '0;
                end else begin
                    last_word = 1'b1;
                end
            end
            S_BODY: if (vld_q) begin
                if (ptr_q == cmd_q.len - WL'(1)) last_word = 1'b1;
                else                             ptr_d = ptr_q + WL'(1);
            end
`ifdef SEND_CHECKSUM_EN
            S_CSUM: if (vld_q) pkt_end = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef SEND_CHECKSUM_EN
        if (last_word) state_d = S_CSUM;
`else
        if (last_word) pkt_end = 1'b1;
`endif

        if (pkt_end) begin
            if (IPG > 0) begin
                state_d = S_GAP;
                gap_d   = '0;
            end else begin
                // no gap: chain straight into the next queued packet
                state_d = S_IDLE;
                launch  = can_launch;
            end
        end

        if (launch) begin
            pop     = 1'b1;
            cmd_d   = q_head;
            state_d = S_HEAD;
            ptr_d   = '0;
        end

        // ---- next output word ----
        hdr          = '0;
        hdr[HW-1:0]  = {seq_q, cmd_d};
        pay          = DATA_WIDTH'({seq_q, 8'h00}) + DATA_WIDTH'(ptr_d) + DATA_WIDTH'(1);
        vld_d        = 1'b0;
        sop_d        = 1'b0;
        eop_d        = 1'b0;
        data_d       = '0;
        case (state_d)
            S_HEAD: begin
                vld_d  = !bus.hold_i;
                sop_d  = 1'b1;
                data_d = hdr;
`ifndef SEND_CHECKSUM_EN
                eop_d  = (cmd_d.len == '0);
`endif
            end
            S_BODY: begin
                vld_d  = !bus.hold_i;
                data_d = pay;
`ifndef SEND_CHECKSUM_EN
                eop_d  = (ptr_d == cmd_d.len - WL'(1));
`endif
            end
`ifdef SEND_CHECKSUM_EN
            S_CSUM: begin
                vld_d  = !bus.hold_i;
                data_d = csum_q;
                eop_d  = 1'b1;
            end
`endif
            default: ;
        endcase

        if (!vld_d) begin
            sop_d  = 1'b0;
            eop_d  = 1'b0;
            data_d = '0;
        end
        done_d = vld_d & eop_d;
        seq_d  = seq_q + 16'(done_d);

`ifdef SEND_CHECKSUM_EN
        csum_d = csum_q;
        if (vld_d) csum_d = (state_d == S_HEAD) ? data_d : (csum_q ^ data_d);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gap_q   <= '0;
            cmd_q   <= '0;
            seq_q   <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
`ifdef SEND_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            cmd_q   <= cmd_d;
            seq_q   <= seq_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            done_q  <= done_d;
            data_q  <= data_d;
`ifdef SEND_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.start_rdy_o = rdy_q;
    assign bus.wr_vld_o    = vld_q;
    assign bus.wr_sop_o    = sop_q;
    assign bus.wr_eop_o    = eop_q;
    assign bus.wr_data_o   = data_q;
    assign bus.done_o      = done_q;
    assign bus.busy_o      = (cnt_q != '0) || (state_q != S_IDLE);
endmodule
